seq_timer: RTL
==============

# seq_timer

Command-driven timer peripheral on the sequencer's output-register bus. One 12-bit command word (4-bit command, 8-bit data) is accepted when the block's one-hot write-enable bit is high. The block returns an 8-bit status/count on its input-register lane. The sequencer polls that lane with wait-nonzero or jump-if-zero instructions to synchronise program flow to elapsed time.

## Interface
Parameters: none.

- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- inst  input  12  command word; [11:8] command code, [7:0] data
- inst_en  input  1  command strobe; this peripheral's bit of the sequencer's oreg_wen
- out  output  8  registered read-back value; drives one sequencer ireg lane

## Operation
Registers:
- period[7:0]
- prescale[7:0]
- ps_count[7:0]
- counter[7:0]
- expired (1 bit)
- sel (0 = flag, 1 = counter)
- state

States:
- Reset: entered while reset is high. Next cycle always goes to Stopped.
- Stopped: counter held.
- Running: counting.
- Expired: counter held at period, expired = 1.
- Error: sticky until reset.

Commands are applied only when inst_en = 1 and state ≠ Reset/Error:
- 0 NOP: no change.
- 1 LDC: period <= data. Takes effect immediately, including in Running.
- 2 LDP: prescale <= data. ps_count is not cleared.
- 3 START: counter <= 0, ps_count <= 0, expired <= 0 → Running. If period = 0 → Expired instead, with expired <= 1. Restarts from any of Stopped/Running/Expired.
- 4 STOP: Running → Stopped; counter and ps_count held. Ignored in Stopped/Expired.
- 5 CLR: counter <= 0, ps_count <= 0, expired <= 0 → Stopped.
- 6 RDC: sel <= 1.
- 7 RDF: sel <= 0.
- 8–15: → Error.

Counting, in Running with no command accepted that cycle:
- tick = (ps_count == prescale).
- On tick: ps_count <= 0. Otherwise ps_count <= ps_count + 1.
- On tick: counter <= counter + 1, modulo 256.
- If on tick (counter + 1) mod 256 == period: expired <= 1 → Expired.
- If period is loaded below the current counter, the counter wraps 255 → 0 and matches on the next pass.

Command priority:
- An accepted command replaces that cycle's counting step entirely.
- No tick is evaluated on a command cycle except NOP/LDP/RDC/RDF/LDC, which do not suppress counting.
- For LDC, the comparison on that cycle uses the newly loaded period.

out:
- Error: 8'hEE.
- sel = 1: counter (next-state value).
- sel = 0: {7'b0, expired} (next-state value).

Reset values:
- state Reset, then Stopped.
- period = 0, prescale = 0, ps_count = 0, counter = 0.
- expired = 0, sel = 0, out = 8'h00.

## Timing
- Command sampled at rising edge with inst_en = 1; its effect is visible on out after that same edge (1-cycle latency).
- Expiry latency: expired goes high at the edge exactly period*(prescale+1) cycles after the START edge, provided there are no intervening STOP/CLR/START.
- The sequencer's WN on this lane releases on the first cycle out ≠ 0.
- reset high mid-count overrides any inst_en. All registers return to reset values at that edge, and out = 0 the following cycle.
- inst_en low: no command; counting continues per state.

## Test plan
- Reset then idle 5 cycles → out = 8'h00, state Stopped, counter = 0.
- LDC 3, LDP 0, START, RDC → out sequence 1, 2, 3 on successive cycles, then holds 3. RDF → out = 8'h01.
- LDC 2, LDP 4, START → expired = 1 exactly 10 cycles after the START edge. out (RDF) is 0 before and 1 from then on.
- START, then STOP after 2 ticks, wait 20 cycles, START → counter restarts from 0. CLR in Expired → out (RDF) = 0, state Stopped.
- LDC 0, START → Expired on the START edge, out = 8'h01. Running with counter = 5 and LDC 2 → counter wraps through 255 → 0 and expires at 2.
- Command code 9 → out = 8'hEE persists through any later commands. Reset clears it to 8'h00. Reset asserted while Running also clears everything.

Source files
------------

// File: rtl/seq_timer.sv
// seq_timer: command-driven prescaled timer on the sequencer's oreg bus.
// Returns the expiry flag or the live count on its ireg lane, and 8'hEE after an illegal command.
module seq_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic [7:0]  out
);
    typedef enum logic [2:0] {S_RESET, S_STOPPED, S_RUNNING, S_EXPIRED, S_ERROR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  period_q, period_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  ps_count_q, ps_count_d;
    logic [7:0]  counter_q, counter_d;
    logic        expired_q, expired_d;
    logic        sel_q, sel_d;
    logic [7:0]  out_d;
    logic [7:0]  cnt_inc;
    logic [3:0]  cmd;
    logic [7:0]  data;
    logic        accept;
    logic        count_ok;

    assign cmd     = inst[11:8];
    assign data    = inst[7:0];
    assign accept  = inst_en && state_q != S_RESET && state_q != S_ERROR;
    assign cnt_inc = counter_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        ps_count_d = ps_count_q;
        counter_d  = counter_q;
        expired_d  = expired_q;
        sel_d      = sel_q;
        count_ok   = 1'b1;
        if (state_q == S_RESET)
            state_d = S_STOPPED;
        else if (accept) begin
            case (cmd)
                4'd0: ;
                4'd1: period_d = data;
                4'd2: prescale_d = data;
                4'd3: begin
                    counter_d  = 8'd0;
                    ps_count_d = 8'd0;
                    expired_d  = (period_q == 8'd0);
                    state_d    = (period_q == 8'd0) ? S_EXPIRED : S_RUNNING;
                    count_ok   = 1'b0;
                end
                4'd4: begin
                    state_d  = (state_q == S_RUNNING) ? S_STOPPED : state_q;
                    count_ok = 1'b0;
                end
                4'd5: begin
                    counter_d  = 8'd0;
                    ps_count_d = 8'd0;
                    expired_d  = 1'b0;
                    state_d    = S_STOPPED;
                    count_ok   = 1'b0;
                end
                4'd6: sel_d = 1'b1;
                4'd7: sel_d = 1'b0;
                default: begin
                    state_d  = S_ERROR;
                    count_ok = 1'b0;
                end
            endcase
        end
        // Loads and read-selects still count, using the values loaded this cycle.
        if (count_ok && state_q == S_RUNNING) begin
            if (ps_count_q == prescale_d) begin
                ps_count_d = 8'd0;
                counter_d  = cnt_inc;
                if (cnt_inc == period_d) begin
                    expired_d = 1'b1;
                    state_d   = S_EXPIRED;
                end
            end else
                ps_count_d = ps_count_q + 8'd1;
        end
        out_d = (state_d == S_ERROR) ? 8'hEE : sel_d ? counter_d : {7'b0, expired_d};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_RESET;
            period_q   <= 8'd0;
            prescale_q <= 8'd0;
            ps_count_q <= 8'd0;
            counter_q  <= 8'd0;
            expired_q  <= 1'b0;
            sel_q      <= 1'b0;
            out        <= 8'h00;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            ps_count_q <= ps_count_d;
            counter_q  <= counter_d;
            expired_q  <= expired_d;
            sel_q      <= sel_d;
            out        <= out_d;
        end
    end
endmodule
